// File: rtl/acf_normalise_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : acf_normalise_buffer_if
//  Purpose  : Bundles the ACF input stream, the normalised output stream and
//             the overflow flag of acf_normalise_buffer.
//  Signals  : iACF/iValid   - ACF words from the autocorrelator (no stall)
//             oACF/oLag/oShift/oValid/iReady - normalised lags, valid/ready
//             oOverflow     - sticky "input word dropped"
//  Modports : slave  - the buffer itself
//             master - the surrounding environment (upstream + downstream)
//  Revision : 1.0  initial release
// ============================================================================
interface acf_normalise_buffer_if #(
    parameter int IN_W  = 43,
    parameter int OUT_W = 32
);
    logic [IN_W-1:0]  iACF;
    logic             iValid;
    logic [OUT_W-1:0] oACF;
    logic [3:0]       oLag;
    logic [4:0]       oShift;
    logic             oValid;
    logic             iReady;
    logic             oOverflow;

    modport slave (
        input  iACF, iValid, iReady,
        output oACF, oLag, oShift, oValid, oOverflow
    );

    modport master (
        output iACF, iValid, iReady,
        input  oACF, oLag, oShift, oValid, oOverflow
    );
endinterface
`default_nettype wire

// File: rtl/acf_normalise_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : acf_normalise_buffer
//  Purpose  : Captures bursts of ORDER+1 ACF lags into a two-bank buffer,
//             picks one right shift per frame so lag 0 fits OUT_W signed,
//             and re-emits the scaled lags with a valid/ready handshake.
//  Ports    : iClock - rising-edge clock
//             iReset - asynchronous active-low reset
//             bus    - acf_normalise_buffer_if.slave (input stream, output
//                      stream, sticky overflow)
//  Options  : ACF_ROUND_EN - round-half-up with positive saturation instead
//                            of plain arithmetic-shift truncation
//  Revision : 1.0  initial release
// ============================================================================
module acf_normalise_buffer #(
    parameter int ORDER = 12,
    parameter int IN_W  = 43,
    parameter int OUT_W = 32
) (
    input  wire logic                 iClock,
    input  wire logic                 iReset,
    acf_normalise_buffer_if.slave     bus
);

    localparam logic [3:0] c_LAST  = 4'(ORDER);
    localparam logic [6:0] c_OUT_W = 7'(OUT_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic signed [IN_W-1:0] r_mem [0:1][0:ORDER];
    logic [1:0]             r_full;
    logic                   r_wr_bank;
    logic [3:0]             r_wr_idx;
    logic                   r_ovf;

    state_t                 r_state;
    logic                   r_rd_bank;
    logic [3:0]             r_rd_idx;
    logic [OUT_W-1:0]       r_acf;
    logic [3:0]             r_lag;
    logic [4:0]             r_shift;
    logic                   r_valid;

    // ------------------------------------------------------------------
    // Scaling of one lag by the frame shift
    // ------------------------------------------------------------------
    function automatic logic [OUT_W-1:0] f_norm(input logic signed [IN_W-1:0] lag,
                                                input logic [4:0]             sh);
`ifdef ACF_ROUND_EN
        logic signed [IN_W:0] sum;
        logic signed [IN_W:0] q;
        localparam logic signed [IN_W:0] c_MAXPOS =
            {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
        if (sh == 5'd0)
            return lag[OUT_W-1:0];
        // One extra bit keeps the half-LSB carry of a near-full-scale lag.
        sum = {lag[IN_W-1], lag} + ({{IN_W{1'b0}}, 1'b1} << (sh - 5'd1));
        q   = sum >>> sh;
        if (q > c_MAXPOS)
            return {1'b0, {(OUT_W-1){1'b1}}};
        return q[OUT_W-1:0];
`else
        return OUT_W'(lag >>> sh);
`endif
    endfunction

    // ------------------------------------------------------------------
    // Capture side
    // ------------------------------------------------------------------
    logic       w_hs;
    logic       w_free;
    logic       w_tgt_busy;
    logic       w_wr_en;
    logic       w_wr_last;
    logic [1:0] w_set;
    logic [1:0] w_clr;
    logic [1:0] w_full_nxt;

    assign w_hs   = r_valid && bus.iReady;
    // The bank being read frees on the handshake of its last lag.
    assign w_free = (r_state == S_EMIT) && w_hs && (r_rd_idx == c_LAST);
    // A write into the bank that frees this very cycle is accepted.
    assign w_tgt_busy = r_full[r_wr_bank] && !(w_free && (r_rd_bank == r_wr_bank));
    assign w_wr_en    = bus.iValid && !w_tgt_busy;
    assign w_wr_last  = w_wr_en && (r_wr_idx == c_LAST);
    assign w_set      = w_wr_last ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr      = w_free    ? (2'b01 << r_rd_bank) : 2'b00;
    // Full flags as they will be after this edge; lets the FSM start the
    // scan in the same cycle the last word lands.
    assign w_full_nxt = r_full | w_set;

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_wr_idx  <= 4'd0;
            r_ovf     <= 1'b0;
        end else begin
            r_full <= (r_full & ~w_clr) | w_set;
            if (bus.iValid && w_tgt_busy) begin
                r_ovf <= 1'b1;
            end else if (w_wr_en) begin
                if (w_wr_last) begin
                    r_wr_idx  <= 4'd0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_idx  <= r_wr_idx + 4'd1;
                end
            end
        end
    end

    // Bank contents need no reset: the full flags gate every read.
    always_ff @(posedge iClock) begin
        if (w_wr_en)
            r_mem[r_wr_bank][r_wr_idx] <= bus.iACF;
    end

    // ------------------------------------------------------------------
    // Shift selection from lag 0 of the bank being read
    // ------------------------------------------------------------------
    logic signed [IN_W-1:0] w_lag0;
    logic [6:0]             w_msb;
    logic [4:0]             w_shift;
    logic [3:0]             w_next_idx;
    logic signed [IN_W-1:0] w_next_word;

    assign w_lag0 = r_mem[r_rd_bank][0];

    always_comb begin
        w_msb = 7'd0;
        for (int i = 0; i < IN_W; i++) begin
            if (w_lag0[i])
                w_msb = 7'(i);
        end
        w_shift = 5'd0;
        if ((w_lag0 != '0) && ((w_msb + 7'd2) > c_OUT_W))
            w_shift = 5'(w_msb + 7'd2 - c_OUT_W);
    end

    // Clamp keeps the read index inside the bank on the last lag.
    assign w_next_idx  = (r_rd_idx == c_LAST) ? r_rd_idx : (r_rd_idx + 4'd1);
    assign w_next_word = r_mem[r_rd_bank][w_next_idx];

    // ------------------------------------------------------------------
    // Output FSM
    // ------------------------------------------------------------------
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            r_state   <= S_IDLE;
            r_rd_bank <= 1'b0;
            r_rd_idx  <= 4'd0;
            r_acf     <= '0;
            r_lag     <= 4'd0;
            r_shift   <= 5'd0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Banks fill and drain in strict alternation, so the
                    // read pointer always names the oldest full bank.
                    if (w_full_nxt[r_rd_bank])
                        r_state <= S_SCAN;
                end
                S_SCAN: begin
                    r_shift  <= w_shift;
                    r_acf    <= f_norm(w_lag0, w_shift);
                    r_lag    <= 4'd0;
                    r_rd_idx <= 4'd0;
                    r_valid  <= 1'b1;
                    r_state  <= S_EMIT;
                end
                S_EMIT: begin
                    if (w_hs) begin
                        if (r_rd_idx == c_LAST) begin
                            r_valid   <= 1'b0;
                            r_rd_bank <= ~r_rd_bank;
                            r_state   <= w_full_nxt[~r_rd_bank] ? S_SCAN : S_IDLE;
                        end else begin
                            r_rd_idx <= w_next_idx;
                            r_lag    <= w_next_idx;
                            r_acf    <= f_norm(w_next_word, r_shift);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oACF      = r_acf;
    assign bus.oLag      = r_lag;
    assign bus.oShift    = r_shift;
    assign bus.oValid    = r_valid;
    assign bus.oOverflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_acf_normalise_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acf_normalise_buffer
//  Purpose  : Directed self-checking bench for acf_normalise_buffer. A
//             monitor compares every handshaked output with a queue of
//             hand-computed expected lags and checks stalled outputs hold.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_acf_normalise_buffer;

    localparam int ORDER = 12;
    localparam int IN_W  = 43;
    localparam int OUT_W = 32;

    logic iClock = 1'b0;
    logic iReset = 1'b0;

    acf_normalise_buffer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    acf_normalise_buffer #(.ORDER(ORDER), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus)
    );

    always #5 iClock = ~iClock;

    typedef struct { longint acf; int lag; int shift; } exp_t;
    exp_t   exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    longint fr [0:ORDER];
    longint ex [0:ORDER];

    task automatic chk(input string tag, input longint got, input longint want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic longint p2(input int n);
        return longint'(1) << n;
    endfunction

    task automatic push_frame(input int sh);
        exp_t e;
        for (int k = 0; k <= ORDER; k++) begin
            e.acf = ex[k]; e.lag = k; e.shift = sh;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame();
        for (int k = 0; k <= ORDER; k++) begin
            @(negedge iClock);
            bus.iValid = 1'b1;
            bus.iACF   = fr[k][IN_W-1:0];
        end
        @(negedge iClock);
        bus.iValid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++)
            @(negedge iClock);
        #2;
        chk({tag, " drained"}, exp_q.size(), 0);
        chk({tag, " valid low"}, bus.oValid, 0);
    endtask

    // ---------------- output monitor ----------------
    logic             prev_stall = 1'b0;
    logic [OUT_W-1:0] p_acf;
    logic [3:0]       p_lag;
    logic [4:0]       p_shift;

    always @(negedge iClock) begin
        exp_t e;
        #1;
        if (!iReset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold acf",   $signed(bus.oACF), $signed(p_acf));
                chk("hold lag",   bus.oLag, p_lag);
                chk("hold shift", bus.oShift, p_shift);
                chk("hold valid", bus.oValid, 1);
            end
            if (bus.oValid && bus.iReady) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("acf lag%0d", e.lag), $signed(bus.oACF), e.acf);
                    chk("lag index", bus.oLag, e.lag);
                    chk($sformatf("shift lag%0d", e.lag), bus.oShift, e.shift);
                end
            end
            prev_stall = bus.oValid && !bus.iReady;
            p_acf = bus.oACF; p_lag = bus.oLag; p_shift = bus.oShift;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.iValid = 1'b0;
        bus.iACF   = '0;
        bus.iReady = 1'b1;
        repeat (3) @(negedge iClock);
        #1;
        chk("reset oValid",    bus.oValid, 0);
        chk("reset oACF",      bus.oACF, 0);
        chk("reset oLag",      bus.oLag, 0);
        chk("reset oShift",    bus.oShift, 0);
        chk("reset oOverflow", bus.oOverflow, 0);
        @(negedge iClock);
        iReset = 1'b1;

        // 1: small frame, shift 0, two-cycle latency
        for (int k = 0; k <= ORDER; k++) begin fr[k] = 1000 - 10*k; ex[k] = fr[k]; end
        push_frame(0);
        send_frame();
        #1;
        chk("t1 valid one cycle after", bus.oValid, 0);
        @(negedge iClock); #1;
        chk("t1 valid two cycles after", bus.oValid, 1);
        chk("t1 first lag", bus.oLag, 0);
        chk("t1 first acf", $signed(bus.oACF), 1000);
        drain("t1");

        // 2: lag0 = 2^40 -> shift 10
        for (int k = 0; k <= ORDER; k++) begin fr[k] = 0; ex[k] = 0; end
        fr[0] = p2(40);      ex[0] = p2(30);
        fr[1] = -3*p2(30);   ex[1] = -3*p2(20);
        fr[2] = -p2(40);     ex[2] = -p2(30);
        push_frame(10);
        send_frame();
        drain("t2");

        // shift threshold: lag0 = 2^31-1 keeps shift 0, lag0 = 2^31 needs 1
        for (int k = 0; k <= ORDER; k++) begin fr[k] = 0; ex[k] = 0; end
        fr[0] = p2(31) - 1;  ex[0] = p2(31) - 1;
        fr[1] = -(p2(31)-1); ex[1] = -(p2(31)-1);
        push_frame(0);
        send_frame();
        fr[0] = p2(31);      ex[0] = p2(30);
        fr[1] = -p2(31);     ex[1] = -p2(30);
        fr[2] = 3;
`ifdef ACF_ROUND_EN
        ex[2] = 2;
`else
        ex[2] = 1;
`endif
        push_frame(1);
        send_frame();
        drain("threshold");

        // largest positive lag0 -> shift 11, output at full scale
        for (int k = 0; k <= ORDER; k++) begin fr[k] = 0; ex[k] = 0; end
        fr[0] = p2(42) - 1;    ex[0] = p2(31) - 1;
        fr[1] = -(p2(42) - 1); ex[1] = -p2(31);
        push_frame(11);
        send_frame();
        drain("full scale");

        // 3: truncation vs rounding of lag 1 at shift 10
        for (int k = 0; k <= ORDER; k++) begin fr[k] = 0; ex[k] = 0; end
        fr[0] = p2(40);            ex[0] = p2(30);
        fr[1] = p2(29) + p2(28);   ex[1] = p2(19) + p2(18);
        push_frame(10);
        send_frame();
        fr[1] = p2(29) + p2(9);
`ifdef ACF_ROUND_EN
        ex[1] = p2(19) + 1;
`else
        ex[1] = p2(19);
`endif
        push_frame(10);
        send_frame();
        drain("t3");

        // 5: iReady toggling every cycle while a frame streams
        for (int k = 0; k <= ORDER; k++) begin fr[k] = 5000 - 300*k; ex[k] = fr[k]; end
        push_frame(0);
        fork
            send_frame();
            begin
                repeat (40) begin
                    @(negedge iClock);
                    bus.iReady = ~bus.iReady;
                end
            end
        join
        @(negedge iClock);
        bus.iReady = 1'b1;
        drain("t5");

        // 4: two frames buffered under back-pressure, third frame overflows
        @(negedge iClock);
        bus.iReady = 1'b0;
        for (int k = 0; k <= ORDER; k++) begin fr[k] = 100 + k; ex[k] = fr[k]; end
        push_frame(0);
        send_frame();
        for (int k = 0; k <= ORDER; k++) begin fr[k] = 200 + k; ex[k] = fr[k]; end
        push_frame(0);
        send_frame();
        #1;
        chk("t4 no overflow", bus.oOverflow, 0);
        chk("t4 stalled valid", bus.oValid, 1);
        @(negedge iClock);
        bus.iValid = 1'b1;
        bus.iACF   = IN_W'(777);
        @(negedge iClock);
        bus.iValid = 1'b0;
        #1;
        chk("t4 overflow set", bus.oOverflow, 1);
        @(negedge iClock);
        bus.iReady = 1'b1;
        drain("t4");
        chk("t4 overflow sticky", bus.oOverflow, 1);

        // 6: reset mid-frame discards the partial frame and clears the flag
        for (int k = 0; k < 5; k++) begin
            @(negedge iClock);
            bus.iValid = 1'b1;
            bus.iACF   = IN_W'(9999);
        end
        @(negedge iClock);
        bus.iValid = 1'b0;
        iReset     = 1'b0;
        #1;
        chk("t6 reset overflow", bus.oOverflow, 0);
        chk("t6 reset valid", bus.oValid, 0);
        @(negedge iClock);
        iReset = 1'b1;
        for (int k = 0; k <= ORDER; k++) begin
            fr[k] = p2(35) - longint'(k) * p2(20);
            ex[k] = p2(30) - longint'(k) * p2(15);
        end
        push_frame(5);
        send_frame();
        for (int k = 0; k <= ORDER; k++) begin fr[k] = 0; ex[k] = 0; end
        push_frame(0);
        send_frame();
        drain("t6");
        chk("t6 overflow clear", bus.oOverflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
